// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial source that feeds the 1011 detector.
package seq_pkg;

  typedef enum logic {
    SER_IDLE,
    SER_SHIFT
  } ser_state_t;

  // Width of the bit-index counter for a given word width.
  function automatic int ser_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_pend_buf.sv
// One-word holding register that lets the next word wait while the current one shifts out.
module seq_pend_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] pend;

  // NOTE: the data word is reset along with the flag so a reset leaves no stale payload visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      pend <= wr_data;
      full <= 1'b1;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

  assign rd_data = pend;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial source: takes WIDTH-bit words over valid/ready and emits one bit per
// clock on dout, streaming back-to-back words gaplessly through a one-word pending buffer.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int            CW       = ser_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic             pend_full;
  logic [WIDTH-1:0] pend_data;
  logic             accept;
  logic             last_bit;
  logic             pend_wr;
  logic             pend_rd;

  // Bit idx of word w in transmission order.
  function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
    return MSB_FIRST ? w[CNT_LAST - idx] : w[idx];
  endfunction

  assign din_ready = !pend_full;
  assign accept    = din_valid && din_ready;
  assign last_bit  = (state == SER_SHIFT) && (cnt == CNT_LAST);
  // Mid-word accepts park in the buffer; a last-bit accept bypasses straight into shreg.
  assign pend_wr   = accept && (state == SER_SHIFT) && !last_bit;
  assign pend_rd   = last_bit && pend_full;

  seq_pend_buf #(
    .WIDTH(WIDTH)
  ) u_pend (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (pend_wr),
    .wr_data(din),
    .rd_en  (pend_rd),
    .rd_data(pend_data),
    .full   (pend_full)
  );

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SER_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        SER_IDLE: begin
          if (accept) begin
            shreg      <= din;
            cnt        <= CNT_ZERO;
            dout       <= pick(din, CNT_ZERO);
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (!last_bit) begin
            cnt  <= cnt + CW'(1);
            dout <= pick(shreg, cnt + CW'(1));
          end else if (pend_full) begin
            shreg <= pend_data;
            cnt   <= CNT_ZERO;
            dout  <= pick(pend_data, CNT_ZERO);
          end else if (accept) begin
            shreg <= din;
            cnt   <= CNT_ZERO;
            dout  <= pick(din, CNT_ZERO);
          end else begin
            // Idle gap drives 0s, which can never complete a spurious 1011 downstream.
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= SER_IDLE;
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule
